// File: rtl/cdb_pkg.sv
// Shared common-data-bus definitions. The reservation station and ROB use the same
// tag widths and result layout.
package cdb_pkg;

    localparam int PREG_W = 6;
    localparam int ROB_W  = 6;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [PREG_W-1:0] rd;
        logic [DATA_W-1:0] value;
        logic [ROB_W-1:0]  rob;
        logic              regwrite;
    } cdb_entry_t;

    localparam int ENTRY_W = $bits(cdb_entry_t);

    function automatic cdb_entry_t make_entry(input logic [PREG_W-1:0] rd,
                                              input logic [DATA_W-1:0] value,
                                              input logic [ROB_W-1:0]  rob,
                                              input logic              regwrite);
        cdb_entry_t e;
        e.rd       = rd;
        e.value    = value;
        e.rob      = rob;
        e.regwrite = regwrite;
        return e;
    endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Per-FU result buffer. DEPTH must be a power of two so the pointers wrap naturally.
// Flush takes priority over push and pop.
module cdb_fifo
    import cdb_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  cdb_entry_t       push_data,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output cdb_entry_t       head
);

    cdb_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign do_push = push && !flush && (count_q < CNT_W'(DEPTH));
    assign do_pop  = pop && !flush && (count_q != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage needs no reset: it is only observed through a non-zero count.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter that drains per-FU result FIFOs onto a single registered CDB.
// Define CDB_BYPASS_EN to let results from an FU with an empty FIFO win on the same edge.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_FU     = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [NUM_FU-1:0]        fu_valid,
    output logic [NUM_FU-1:0]        fu_ready,
    input  logic [PREG_W*NUM_FU-1:0] fu_rd,
    input  logic [DATA_W*NUM_FU-1:0] fu_value,
    input  logic [ROB_W*NUM_FU-1:0]  fu_rob,
    input  logic [NUM_FU-1:0]        fu_regwrite,
    output logic                     cdb_valid,
    output logic [PREG_W-1:0]        cdb_rd,
    output logic [DATA_W-1:0]        cdb_value,
    output logic [ROB_W-1:0]         cdb_rob,
    output logic                     cdb_regwrite
);

    localparam int RR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    cdb_entry_t        in_entry [NUM_FU];
    cdb_entry_t        head     [NUM_FU];
    logic [CNT_W-1:0]  count    [NUM_FU];
    logic [NUM_FU-1:0] accept, push, pop, nonempty, cand, grant;

    logic [RR_W-1:0] rr_ptr_q, rr_ptr_d;
    cdb_entry_t      cdb_q, cdb_d;
    logic            cdb_valid_q, cdb_valid_d;

    for (genvar g = 0; g < NUM_FU; g++) begin : g_fu
        assign in_entry[g] = make_entry(fu_rd[PREG_W*g +: PREG_W], fu_value[DATA_W*g +: DATA_W],
                                        fu_rob[ROB_W*g +: ROB_W], fu_regwrite[g]);
        assign fu_ready[g] = count[g] < CNT_W'(FIFO_DEPTH);
        assign nonempty[g] = count[g] != '0;
        assign accept[g]   = fu_valid[g] & fu_ready[g];
`ifdef CDB_BYPASS_EN
        // A granted result from an empty FIFO goes straight to the CDB instead of being buffered.
        assign cand[g] = nonempty[g] | accept[g];
        assign push[g] = accept[g] & ~(grant[g] & ~nonempty[g]);
`else
        assign cand[g] = nonempty[g];
        assign push[g] = accept[g];
`endif
        assign pop[g] = grant[g] & nonempty[g];

        cdb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .push      (push[g]),
            .push_data (in_entry[g]),
            .pop       (pop[g]),
            .count     (count[g]),
            .head      (head[g])
        );
    end

    always_comb begin
        int idx;
        logic found;
        idx         = 0;
        found       = 1'b0;
        grant       = '0;
        cdb_d       = cdb_q;
        cdb_valid_d = 1'b0;
        rr_ptr_d    = rr_ptr_q;
        for (int k = 0; k < NUM_FU; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_FU;
            if (!found && cand[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                cdb_valid_d = 1'b1;
                cdb_d       = nonempty[idx] ? head[idx] : in_entry[idx];
                rr_ptr_d    = RR_W'((idx + 1) % NUM_FU);
            end
        end
        if (flush) begin
            cdb_valid_d = 1'b0;
            cdb_d       = cdb_q;
            rr_ptr_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_q       <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_q       <= cdb_d;
        end
    end

    assign cdb_valid    = cdb_valid_q;
    assign cdb_rd       = cdb_q.rd;
    assign cdb_value    = cdb_q.value;
    assign cdb_rob      = cdb_q.rob;
    assign cdb_regwrite = cdb_q.regwrite;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed table, corner-case sequences and random traffic
// checked against a queue-based reference model. Honours CDB_BYPASS_EN.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int NUM_FU     = 4;
    localparam int FIFO_DEPTH = 2;
`ifdef CDB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     reset, flush;
    logic [NUM_FU-1:0]        fu_valid, fu_ready, fu_regwrite;
    logic [PREG_W*NUM_FU-1:0] fu_rd;
    logic [DATA_W*NUM_FU-1:0] fu_value;
    logic [ROB_W*NUM_FU-1:0]  fu_rob;
    logic                     cdb_valid, cdb_regwrite;
    logic [PREG_W-1:0]        cdb_rd;
    logic [DATA_W-1:0]        cdb_value;
    logic [ROB_W-1:0]         cdb_rob;

    always #5 clk = ~clk;

    cdb_arbiter #(.NUM_FU(NUM_FU), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_rd(fu_rd), .fu_value(fu_value),
        .fu_rob(fu_rob), .fu_regwrite(fu_regwrite),
        .cdb_valid(cdb_valid), .cdb_rd(cdb_rd), .cdb_value(cdb_value),
        .cdb_rob(cdb_rob), .cdb_regwrite(cdb_regwrite)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: one queue per FU, an integer round-robin pointer, the expected CDB.
    cdb_entry_t mq [NUM_FU][$];
    int         m_rr;
    logic       m_valid;
    cdb_entry_t m_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic cdb_entry_t incoming(input int i);
        cdb_entry_t e;
        e.rd       = fu_rd[PREG_W*i +: PREG_W];
        e.value    = fu_value[DATA_W*i +: DATA_W];
        e.rob      = fu_rob[ROB_W*i +: ROB_W];
        e.regwrite = fu_regwrite[i];
        return e;
    endfunction

    task automatic set_fu(input int i, input logic [5:0] rd, input logic [31:0] v,
                          input logic [5:0] rob, input logic rw);
        fu_rd[PREG_W*i +: PREG_W]    = rd;
        fu_value[DATA_W*i +: DATA_W] = v;
        fu_rob[ROB_W*i +: ROB_W]     = rob;
        fu_regwrite[i]               = rw;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_FU; i++) mq[i].delete();
        m_rr    = 0;
        m_valid = 1'b0;
        m_e     = '0;
    endtask

    task automatic model_edge();
        bit         acc [NUM_FU];
        int         win;
        cdb_entry_t e;
        if (flush) begin
            for (int i = 0; i < NUM_FU; i++) mq[i].delete();
            m_valid = 1'b0;
            m_rr    = 0;
            return;
        end
        win = -1;
        for (int i = 0; i < NUM_FU; i++) acc[i] = fu_valid[i] && (mq[i].size() < FIFO_DEPTH);
        for (int k = 0; k < NUM_FU; k++) begin
            int idx;
            idx = (m_rr + k) % NUM_FU;
            if (win < 0 && (mq[idx].size() > 0 || (BYP && acc[idx]))) win = idx;
        end
        m_valid = (win >= 0);
        if (win >= 0) begin
            if (mq[win].size() > 0) e = mq[win].pop_front();
            else begin
                e = incoming(win);
                acc[win] = 1'b0;
            end
            m_e  = e;
            m_rr = (win + 1) % NUM_FU;
        end
        for (int i = 0; i < NUM_FU; i++) if (acc[i]) mq[i].push_back(incoming(i));
    endtask

    // One clock: check ready before the edge, advance the model, compare CDB after the edge.
    task automatic cycle();
        for (int i = 0; i < NUM_FU; i++)
            check($sformatf("fu_ready[%0d]", i), 64'(fu_ready[i]), 64'(mq[i].size() < FIFO_DEPTH));
        model_edge();
        @(posedge clk);
        #1;
        check("cdb_valid", 64'(cdb_valid), 64'(m_valid));
        check("cdb_fields", 64'({cdb_rd, cdb_value, cdb_rob, cdb_regwrite}), 64'(m_e));
    endtask

    typedef struct packed {
        logic [3:0] valid;
        logic       exp_v_nb;
        logic [5:0] exp_rd_nb;
        logic       exp_v_b;
        logic [5:0] exp_rd_b;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seq [NUM_FU];
        int prev, n2, k2, bcast;
        logic [3:0] acc_pre;

        reset = 1'b0; flush = 1'b0; fu_valid = '0; fu_rd = '0; fu_value = '0;
        fu_rob = '0; fu_regwrite = '0;
        model_reset();
        #12;
        check("rst_cdb_valid", 64'(cdb_valid), 64'(0));
        check("rst_fields", 64'({cdb_rd, cdb_value, cdb_rob, cdb_regwrite}), 64'(0));
        check("rst_ready", 64'(fu_ready), 64'hF);
        @(negedge clk) reset = 1'b1;

        // Directed table; FU i in row r carries rd = 8r+i+1
        tbl[0] = '{4'b0001, 1'b0, 6'd0,  1'b1, 6'd1};
        tbl[1] = '{4'b0000, 1'b1, 6'd1,  1'b0, 6'd1};
        tbl[2] = '{4'b0110, 1'b0, 6'd1,  1'b1, 6'd18};
        tbl[3] = '{4'b0000, 1'b1, 6'd18, 1'b1, 6'd19};
        tbl[4] = '{4'b0000, 1'b1, 6'd19, 1'b0, 6'd19};
        tbl[5] = '{4'b0000, 1'b0, 6'd19, 1'b0, 6'd19};
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NUM_FU; i++)
                set_fu(i, 6'(8*r + i + 1), 32'hAAAA_AA00 | 32'(8*r + i + 1), 6'(8*r + i + 1), 1'b1);
            fu_valid = tbl[r].valid;
            cycle();
            check($sformatf("tbl%0d_valid", r), 64'(cdb_valid), 64'(BYP ? tbl[r].exp_v_b : tbl[r].exp_v_nb));
            check($sformatf("tbl%0d_rd", r), 64'(cdb_rd), 64'(BYP ? tbl[r].exp_rd_b : tbl[r].exp_rd_nb));
        end
        fu_valid = '0;

        // Idle hold after a broadcast
        set_fu(3, 6'd4, 32'hCCCC_CCCC, 6'd5, 1'b1);
        fu_valid = 4'b1000;
        cycle();
        fu_valid = '0;
        repeat (6) cycle();
        check("hold_valid", 64'(cdb_valid), 64'(0));
        check("hold_rd", 64'(cdb_rd), 64'(4));
        check("hold_value", 64'(cdb_value), 64'hCCCC_CCCC);

        // Fairness: all FUs valid every cycle, grants must rotate
        for (int i = 0; i < NUM_FU; i++) seq[i] = 0;
        prev = -1;
        for (int c = 0; c < 24; c++) begin
            for (int i = 0; i < NUM_FU; i++)
                set_fu(i, 6'(i), {16'(i), 16'(seq[i])}, 6'(i*16 + (seq[i] % 16)), 1'b1);
            fu_valid = 4'hF;
            acc_pre = fu_valid & fu_ready;
            cycle();
            for (int i = 0; i < NUM_FU; i++) if (acc_pre[i]) seq[i]++;
            if (cdb_valid) begin
                if (prev >= 0) check("rr_order", 64'(cdb_rob >> 4), 64'((prev + 1) % NUM_FU));
                prev = int'(cdb_rob >> 4);
            end
        end
        fu_valid = '0;
        repeat (12) cycle();

        // Asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) set_fu(i, 6'(20 + i), 32'h1234_0000 + i, 6'(20 + i), 1'b1);
        fu_valid = 4'b0111;
        cycle();
        fu_valid = '0;
        #3 reset = 1'b0;
        #1;
        model_reset();
        check("mrst_valid", 64'(cdb_valid), 64'(0));
        check("mrst_fields", 64'({cdb_rd, cdb_value, cdb_rob, cdb_regwrite}), 64'(0));
        check("mrst_ready", 64'(fu_ready), 64'hF);
        @(negedge clk) reset = 1'b1;
        repeat (5) cycle();

        // FU2 fills its FIFO while competing with FU0/FU1; its held result must arrive once
        k2 = 0; n2 = 0;
        for (int c = 0; c < 20 && k2 < 3; c++) begin
            set_fu(0, 6'd1, 32'h0000_0000 + c, 6'(c % 8), 1'b1);
            set_fu(1, 6'd2, 32'h1111_0000 + c, 6'(8 + c % 8), 1'b0);
            set_fu(2, 6'd3, 32'h2222_0000 + k2, 6'(40 + k2), 1'b1);
            fu_valid = 4'b0111;
            acc_pre = fu_valid & fu_ready;
            cycle();
            if (acc_pre[2]) k2++;
            if (c == 1) check("full_ready2", 64'(fu_ready[2]), 64'(0));
            if (cdb_valid && cdb_rob >= 6'd40 && cdb_rob <= 6'd42) begin
                check("full_order", 64'(cdb_rob), 64'(40 + n2));
                n2++;
            end
        end
        fu_valid = '0;
        for (int c = 0; c < 12; c++) begin
            cycle();
            if (cdb_valid && cdb_rob >= 6'd40 && cdb_rob <= 6'd42) begin
                check("full_order", 64'(cdb_rob), 64'(40 + n2));
                n2++;
            end
        end
        check("full_count", 64'(n2), 64'(3));

        // Flush with buffered results; flush also squashes same-edge inputs
        for (int i = 0; i < NUM_FU; i++) set_fu(i, 6'(30 + i), 32'h5555_0000 + i, 6'(30 + i), 1'b1);
        fu_valid = 4'hF;
        cycle();
        fu_valid = 4'b0011;
        cycle();
        fu_valid = 4'hF;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        fu_valid = '0;
        check("flush_valid", 64'(cdb_valid), 64'(0));
        check("flush_ready", 64'(fu_ready), 64'hF);
        bcast = 0;
        repeat (4) begin
            cycle();
            if (cdb_valid) bcast++;
        end
        check("flush_stale", 64'(bcast), 64'(0));

        // Random traffic with occasional flush
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NUM_FU; i++)
                set_fu(i, 6'($urandom), $urandom, 6'($urandom), 1'($urandom));
            fu_valid = 4'($urandom);
            flush = ($urandom_range(0, 49) == 0);
            cycle();
        end
        flush = 1'b0;
        fu_valid = '0;
        repeat (10) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
